// File: rtl/bldcm_pwm_generator_pkg.sv
// ---------------------------------------------------------------------------
// bldcm_pwm_generator_pkg
// Shared constants and types for the BLDC half-bridge PWM carrier generator.
//   state_e      : FSM encoding (IDLE=0, RUN=1, FAULT=2)
//   RESET_PERIOD : period held in the active/pending buffers after reset
//   MIN_PERIOD   : smallest effective period; shorter requests are clamped
// ---------------------------------------------------------------------------
package bldcm_pwm_generator_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FAULT = 2'd2
  } state_e;

  localparam int RESET_PERIOD = 2;
  localparam int MIN_PERIOD   = 2;

endpackage

// File: rtl/bldcm_pwm_generator_if.sv
// ---------------------------------------------------------------------------
// bldcm_pwm_generator_if
// Period/duty update channel of the PWM generator.
//   period, duty : requested period and high-side on-time (clocks)
//   update       : one-cycle strobe that captures period/duty as pending
//   update_ack   : one-cycle pulse when pending values become active
// master drives the request side, slave owns the shadow buffers.
// ---------------------------------------------------------------------------
interface bldcm_pwm_generator_if #(
  parameter int pWidthCnt = 10
);

  logic [pWidthCnt-1:0] period;
  logic [pWidthCnt-1:0] duty;
  logic                 update;
  logic                 update_ack;

  modport master (output period, output duty, output update, input update_ack);
  modport slave  (input period, input duty, input update, output update_ack);

endinterface

// File: rtl/bldcm_pwm_shadow_reg.sv
// ---------------------------------------------------------------------------
// bldcm_pwm_shadow_reg
// Double buffer for PWM period and duty.
//   iClock, iReset_n : clock, synchronous active-low reset
//   load             : direct load of bus.period/bus.duty into active (run entry)
//   boundary         : last clock of a period that continues into another period
//   bus (slave)      : update request channel; update_ack is registered here
//   act_period/duty  : values of the period in progress
//   nxt_period/duty  : values that will be active after the coming edge
// ---------------------------------------------------------------------------
module bldcm_pwm_shadow_reg
  import bldcm_pwm_generator_pkg::*;
#(
  parameter int pWidthCnt = 10
) (
  input  logic                  iClock,
  input  logic                  iReset_n,
  input  logic                  load,
  input  logic                  boundary,
  bldcm_pwm_generator_if.slave  bus,
  output logic [pWidthCnt-1:0]  act_period,
  output logic [pWidthCnt-1:0]  act_duty,
  output logic [pWidthCnt-1:0]  nxt_period,
  output logic [pWidthCnt-1:0]  nxt_duty
);

  logic [pWidthCnt-1:0] act_period_r;
  logic [pWidthCnt-1:0] act_duty_r;
  logic [pWidthCnt-1:0] pend_period_r;
  logic [pWidthCnt-1:0] pend_duty_r;
  logic                 pend_r;
  logic                 ack_r;
  logic                 apply_s;

  // A pending set must already be present before the boundary edge; a strobe
  // in the boundary cycle itself waits for the following boundary.
  assign apply_s = boundary && pend_r;

  // Select the values active after the next edge.
  always_comb begin
    nxt_period = act_period_r;
    nxt_duty   = act_duty_r;
    if (load) begin
      nxt_period = bus.period;
      nxt_duty   = bus.duty;
    end else if (apply_s) begin
      nxt_period = pend_period_r;
      nxt_duty   = pend_duty_r;
    end else begin
      nxt_period = act_period_r;
      nxt_duty   = act_duty_r;
    end
  end

  // Active/pending buffers, pending flag and acknowledge pulse.
  always_ff @(posedge iClock) begin
    if (!iReset_n) begin
      act_period_r  <= pWidthCnt'(RESET_PERIOD);
      act_duty_r    <= {pWidthCnt{1'b0}};
      pend_period_r <= pWidthCnt'(RESET_PERIOD);
      pend_duty_r   <= {pWidthCnt{1'b0}};
      pend_r        <= 1'b0;
      ack_r         <= 1'b0;
    end else begin
      act_period_r <= nxt_period;
      act_duty_r   <= nxt_duty;
      ack_r        <= apply_s && !load;
      if (load) begin
        pend_r <= 1'b0;
      end else if (bus.update) begin
        pend_period_r <= bus.period;
        pend_duty_r   <= bus.duty;
        pend_r        <= 1'b1;
      end else if (apply_s) begin
        pend_r <= 1'b0;
      end
    end
  end

  assign act_period     = act_period_r;
  assign act_duty       = act_duty_r;
  assign bus.update_ack = ack_r;

endmodule

// File: rtl/bldcm_pwm_generator.sv
// ---------------------------------------------------------------------------
// bldcm_pwm_generator
// Edge-aligned PWM carrier for one BLDC half-bridge with complementary gate
// requests, double-buffered period/duty and a latched fault.
//   iClock, iReset_n    : clock, synchronous active-low reset
//   iEnable, iFault     : run request level, fault level (latched)
//   iPeriod, iDuty      : requested period / high-side on-time in clocks
//   iUpdate             : strobe capturing iPeriod/iDuty as pending values
//   oPwmH, oPwmL        : registered high-/low-side gate requests
//   oCycleStart         : pulse on the first clock of every period
//   oUpdateAck          : pulse when pending values become active
//   oFaulted            : high while in FAULT
// ---------------------------------------------------------------------------
module bldcm_pwm_generator
  import bldcm_pwm_generator_pkg::*;
#(
  parameter int pWidthCnt = 10
) (
  input  logic                 iClock,
  input  logic                 iReset_n,
  input  logic                 iEnable,
  input  logic                 iFault,
  input  logic [pWidthCnt-1:0] iPeriod,
  input  logic [pWidthCnt-1:0] iDuty,
  input  logic                 iUpdate,
  output logic                 oPwmH,
  output logic                 oPwmL,
  output logic                 oCycleStart,
  output logic                 oUpdateAck,
  output logic                 oFaulted
);

  state_e               state_r;
  state_e               state_nxt_s;
  logic [pWidthCnt-1:0] cnt_r;
  logic [pWidthCnt-1:0] cnt_nxt_s;
  logic [pWidthCnt-1:0] act_period_s;
  logic [pWidthCnt-1:0] act_duty_s;
  logic [pWidthCnt-1:0] nxt_period_s;
  logic [pWidthCnt-1:0] nxt_duty_s;
  logic [pWidthCnt-1:0] eff_period_s;
  logic                 at_end_s;
  logic                 load_s;
  logic                 boundary_s;
  logic                 pwm_h_nxt_s;
  logic                 pwm_l_nxt_s;
  logic                 cycle_start_nxt_s;
  logic                 faulted_nxt_s;
  logic                 pwm_h_r;
  logic                 pwm_l_r;
  logic                 cycle_start_r;
  logic                 faulted_r;

  bldcm_pwm_generator_if #(.pWidthCnt(pWidthCnt)) shadow_bus ();

  assign shadow_bus.period = iPeriod;
  assign shadow_bus.duty   = iDuty;
  assign shadow_bus.update = iUpdate;

  bldcm_pwm_shadow_reg #(.pWidthCnt(pWidthCnt)) u_shadow (
    .iClock     (iClock),
    .iReset_n   (iReset_n),
    .load       (load_s),
    .boundary   (boundary_s),
    .bus        (shadow_bus),
    .act_period (act_period_s),
    .act_duty   (act_duty_s),
    .nxt_period (nxt_period_s),
    .nxt_duty   (nxt_duty_s)
  );

  // act_duty_s is unused here: the output compare always looks at the duty
  // that will be active after the edge so a new period starts with new values.
  assign eff_period_s = (act_period_s < pWidthCnt'(MIN_PERIOD)) ? pWidthCnt'(MIN_PERIOD)
                                                                : act_period_s;
  // >= rather than == so a corrupted counter still wraps at the period end.
  assign at_end_s   = (cnt_r >= (eff_period_s - pWidthCnt'(1)));
  assign load_s     = (state_r == ST_IDLE) && (state_nxt_s == ST_RUN);
  // Disable or fault in the last clock abandons the period: no boundary.
  assign boundary_s = (state_r == ST_RUN) && (state_nxt_s == ST_RUN) && at_end_s;

  // State register.
  always_ff @(posedge iClock) begin
    if (!iReset_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; fault has priority over disable.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (iFault) begin
          state_nxt_s = ST_FAULT;
        end else if (iEnable) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (iFault) begin
          state_nxt_s = ST_FAULT;
        end else if (!iEnable) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_FAULT: begin
        if (!iEnable && !iFault) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_FAULT;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Next counter and output values, registered together below.
  always_comb begin
    cnt_nxt_s = {pWidthCnt{1'b0}};
    if ((state_r == ST_RUN) && (state_nxt_s == ST_RUN) && !at_end_s) begin
      cnt_nxt_s = cnt_r + pWidthCnt'(1);
    end else begin
      cnt_nxt_s = {pWidthCnt{1'b0}};
    end
    if (state_nxt_s == ST_RUN) begin
      pwm_h_nxt_s = (cnt_nxt_s < nxt_duty_s);
      pwm_l_nxt_s = !(cnt_nxt_s < nxt_duty_s);
    end else begin
      pwm_h_nxt_s = 1'b0;
      pwm_l_nxt_s = 1'b0;
    end
    cycle_start_nxt_s = load_s || boundary_s;
    faulted_nxt_s     = (state_nxt_s == ST_FAULT);
  end

  // Counter and output registers.
  always_ff @(posedge iClock) begin
    if (!iReset_n) begin
      cnt_r         <= {pWidthCnt{1'b0}};
      pwm_h_r       <= 1'b0;
      pwm_l_r       <= 1'b0;
      cycle_start_r <= 1'b0;
      faulted_r     <= 1'b0;
    end else begin
      cnt_r         <= cnt_nxt_s;
      pwm_h_r       <= pwm_h_nxt_s;
      pwm_l_r       <= pwm_l_nxt_s;
      cycle_start_r <= cycle_start_nxt_s;
      faulted_r     <= faulted_nxt_s;
    end
  end

  assign oPwmH       = pwm_h_r;
  assign oPwmL       = pwm_l_r;
  assign oCycleStart = cycle_start_r;
  assign oUpdateAck  = shadow_bus.update_ack;
  assign oFaulted    = faulted_r;

endmodule

// File: tb/tb_bldcm_pwm_generator.sv
// ---------------------------------------------------------------------------
// tb_bldcm_pwm_generator
// Vector table of {inputs, expected outputs}; each record is applied for one
// clock and the registered outputs are compared 1 time unit after the edge.
// Expected outputs are {H, L, CycleStart, UpdateAck, Faulted}.
// ---------------------------------------------------------------------------
module tb_bldcm_pwm_generator;

  localparam int W = 10;

  typedef struct {
    logic         rst_n;
    logic         en;
    logic         flt;
    logic [W-1:0] per;
    logic [W-1:0] dut;
    logic         upd;
    logic [4:0]   exp;
  } vec_t;

  vec_t vecs[$];

  logic clk = 1'b0;
  logic rst_n;
  logic en;
  logic flt;
  logic h, l, cs, fo;
  int   compared   = 0;
  int   mismatched = 0;
  bit   checking   = 1'b0;

  bldcm_pwm_generator_if #(.pWidthCnt(W)) upd_if ();

  bldcm_pwm_generator #(.pWidthCnt(W)) dut (
    .iClock      (clk),
    .iReset_n    (rst_n),
    .iEnable     (en),
    .iFault      (flt),
    .iPeriod     (upd_if.period),
    .iDuty       (upd_if.duty),
    .iUpdate     (upd_if.update),
    .oPwmH       (h),
    .oPwmL       (l),
    .oCycleStart (cs),
    .oUpdateAck  (upd_if.update_ack),
    .oFaulted    (fo)
  );

  always #5 clk = ~clk;

  // Gate requests must never overlap.
  always @(negedge clk) begin
    if (checking) begin
      compared++;
      if ((h & l) !== 1'b0) begin
        mismatched++;
        $display("FAIL h_and_l t=%0t got H=%b L=%b required not both 1", $time, h, l);
      end
    end
  end

  task automatic push(input logic r, input logic e, input logic f,
                      input logic [W-1:0] p, input logic [W-1:0] d, input logic u,
                      input logic eh, input logic el, input logic ec,
                      input logic ea, input logic ef);
    vec_t v;
    v.rst_n = r;
    v.en    = e;
    v.flt   = f;
    v.per   = p;
    v.dut   = d;
    v.upd   = u;
    v.exp   = {eh, el, ec, ea, ef};
    vecs.push_back(v);
  endtask

  // n running clocks, counter going start, start+1, ... modulo peff.
  task automatic run(input logic [W-1:0] p, input logic [W-1:0] d,
                     input int peff, input int dact, input int n, input int start);
    for (int i = 0; i < n; i++) begin
      int c;
      c = (start + i) % peff;
      push(1'b1, 1'b1, 1'b0, p, d, 1'b0, (c < dact), !(c < dact), (c == 0), 1'b0, 1'b0);
    end
  endtask

  task automatic idle_rec(input logic e, input logic [W-1:0] p, input logic [W-1:0] d,
                          input logic u);
    push(1'b1, e, 1'b0, p, d, u, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [4:0] got;
    rst_n = 1'b0;
    en = 1'b0;
    flt = 1'b0;
    upd_if.period = 10'd10;
    upd_if.duty = 10'd3;
    upd_if.update = 1'b0;

    // Reset, then P=10 D=3 for five periods.
    push(1'b0, 1'b0, 1'b0, 10'd10, 10'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    push(1'b0, 1'b0, 1'b0, 10'd10, 10'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle_rec(1'b0, 10'd10, 10'd3, 1'b0);
    run(10'd10, 10'd3, 10, 3, 50, 0);

    // Strobes at cnt 4 (D=7) and 5 (D=5): current period stays 3/7, 5/5 after ack.
    run(10'd10, 10'd3, 10, 3, 5, 0);
    push(1'b1, 1'b1, 1'b0, 10'd10, 10'd7, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    push(1'b1, 1'b1, 1'b0, 10'd10, 10'd5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    run(10'd10, 10'd5, 10, 3, 3, 7);
    push(1'b1, 1'b1, 1'b0, 10'd10, 10'd5, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    run(10'd10, 10'd5, 10, 5, 9, 1);

    // Strobe D=7 in the boundary cycle: no ack now, 7/3 after the next boundary.
    push(1'b1, 1'b1, 1'b0, 10'd10, 10'd7, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    run(10'd10, 10'd7, 10, 5, 9, 1);
    push(1'b1, 1'b1, 1'b0, 10'd10, 10'd7, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    run(10'd10, 10'd7, 10, 7, 9, 1);

    // Disable at cnt 3, re-enable with D=0, then D=10, D=1023, P=0, P=1.
    run(10'd10, 10'd7, 10, 7, 4, 0);
    idle_rec(1'b0, 10'd10, 10'd0, 1'b0);
    run(10'd10, 10'd0, 10, 0, 20, 0);
    idle_rec(1'b0, 10'd10, 10'd10, 1'b0);
    run(10'd10, 10'd10, 10, 10, 12, 0);
    idle_rec(1'b0, 10'd10, 10'd1023, 1'b0);
    run(10'd10, 10'd1023, 10, 1023, 12, 0);
    idle_rec(1'b0, 10'd0, 10'd1, 1'b0);
    run(10'd0, 10'd1, 2, 1, 6, 0);
    idle_rec(1'b0, 10'd1, 10'd1, 1'b0);
    run(10'd1, 10'd1, 2, 1, 6, 0);

    // Strobe outside RUN is overridden by the direct load; never acked.
    idle_rec(1'b0, 10'd10, 10'd9, 1'b1);
    idle_rec(1'b0, 10'd10, 10'd2, 1'b0);
    run(10'd10, 10'd2, 10, 2, 25, 0);

    // Fault at cnt 2 while H=1, latched until enable and fault are both low.
    idle_rec(1'b0, 10'd10, 10'd3, 1'b0);
    run(10'd10, 10'd3, 10, 3, 3, 0);
    push(1'b1, 1'b1, 1'b1, 10'd10, 10'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      push(1'b1, 1'b1, 1'b0, 10'd10, 10'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    end
    push(1'b1, 1'b0, 1'b1, 10'd10, 10'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle_rec(1'b0, 10'd10, 10'd3, 1'b0);
    // Fault from IDLE, and fault beating enable from IDLE.
    push(1'b1, 1'b0, 1'b1, 10'd10, 10'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle_rec(1'b0, 10'd10, 10'd3, 1'b0);
    push(1'b1, 1'b1, 1'b1, 10'd10, 10'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    push(1'b1, 1'b1, 1'b0, 10'd10, 10'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle_rec(1'b0, 10'd10, 10'd3, 1'b0);

    // Reset mid-RUN with a pending D=8: no ack and D=3 split after release.
    run(10'd10, 10'd3, 10, 3, 4, 0);
    push(1'b1, 1'b1, 1'b0, 10'd10, 10'd8, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    push(1'b0, 1'b1, 1'b0, 10'd10, 10'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    push(1'b0, 1'b1, 1'b0, 10'd10, 10'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    run(10'd10, 10'd3, 10, 3, 25, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      rst_n = vecs[i].rst_n;
      en = vecs[i].en;
      flt = vecs[i].flt;
      upd_if.period = vecs[i].per;
      upd_if.duty = vecs[i].dut;
      upd_if.update = vecs[i].upd;
      @(posedge clk);
      #1;
      checking = 1'b1;
      got = {h, l, cs, upd_if.update_ack, fo};
      compared++;
      if (got !== vecs[i].exp) begin
        mismatched++;
        $display("FAIL vec%0d {H,L,CS,ACK,FLT} got %b required %b", i, got, vecs[i].exp);
      end
    end

    checking = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
